// File: rtl/nf_uart_rx_ctrl.sv
// Receive-side controller for nf_uart_receiver: owns enable/baud config, acknowledges
// each received byte and buffers it in a small FWFT FIFO with sticky overrun.
module nf_uart_rx_ctrl #(
    parameter int          FIFO_DEPTH   = 4,
    parameter logic [15:0] DEFAULT_COMP = 16'd434
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          cfg_en,
    input  logic                          cfg_we,
    input  logic [15:0]                   cfg_comp,
    output logic                          cfg_err,
    input  logic                          pop,
    output logic [7:0]                    rd_data,
    output logic                          fifo_empty,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
    output logic                          overrun,
    input  logic                          ovr_clr,
    output logic                          rec_en,
    output logic [15:0]                   comp,
    input  logic [7:0]                    rx_data,
    input  logic                          rx_valid,
    output logic                          rx_val_set
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_CAPTURE  = 2'd2,
        ST_WAIT_CLR = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic              rec_en_s;
    logic              val_set_s;
    logic              cfg_err_s;
    logic [15:0]       comp_next_s;
    logic              rec_en_r;
    logic              val_set_r;
    logic              cfg_err_r;
    logic [15:0]       comp_r;

    logic [7:0]        mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_next_s;
    logic              empty_r;
    logic              full_r;
    logic              overrun_r;
    logic              overrun_next_s;
    logic [7:0]        rd_data_r;
    logic [7:0]        rd_data_next_s;
    logic              capture_s;
    logic              push_s;
    logic              pop_s;
    logic              ovr_set_s;

    // FSM state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic; a pending byte always wins over a disable request
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cfg_en) state_next_s = ST_RUN;
                else        state_next_s = ST_IDLE;
            end
            ST_RUN: begin
                if (rx_valid)     state_next_s = ST_CAPTURE;
                else if (!cfg_en) state_next_s = ST_IDLE;
                else              state_next_s = ST_RUN;
            end
            ST_CAPTURE: begin
                state_next_s = ST_WAIT_CLR;
            end
            ST_WAIT_CLR: begin
                if (rx_valid)    state_next_s = ST_WAIT_CLR;
                else if (cfg_en) state_next_s = ST_RUN;
                else             state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM outputs, computed from the next state so the registered copies track the state
    always_comb begin
        rec_en_s    = (state_next_s != ST_IDLE);
        val_set_s   = (state_next_s == ST_CAPTURE);
        cfg_err_s   = 1'b0;
        comp_next_s = comp_r;
        if (cfg_we) begin
            if (state_r == ST_IDLE) begin
                comp_next_s = cfg_comp;
            end else begin
                cfg_err_s = 1'b1;
            end
        end else begin
            cfg_err_s = 1'b0;
        end
    end

    // Registered control outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rec_en_r  <= 1'b0;
            val_set_r <= 1'b0;
            cfg_err_r <= 1'b0;
            comp_r    <= DEFAULT_COMP;
        end else begin
            rec_en_r  <= rec_en_s;
            val_set_r <= val_set_s;
            cfg_err_r <= cfg_err_s;
            comp_r    <= comp_next_s;
        end
    end

    // FIFO control: a full FIFO still accepts the byte when the head is popped in the same cycle
    always_comb begin
        capture_s = (state_r == ST_CAPTURE);
        pop_s     = pop && !empty_r;
        push_s    = capture_s && (!full_r || pop);
        ovr_set_s = capture_s && full_r && !pop;
        case ({push_s, pop_s})
            2'b10:   cnt_next_s = cnt_r + CNT_ONE;
            2'b01:   cnt_next_s = cnt_r - CNT_ONE;
            default: cnt_next_s = cnt_r;
        endcase
        if (ovr_set_s)    overrun_next_s = 1'b1;
        else if (ovr_clr) overrun_next_s = 1'b0;
        else              overrun_next_s = overrun_r;
        rd_data_next_s = rd_data_r;
        if (push_s && empty_r) begin
            rd_data_next_s = rx_data;
        end else if (pop_s) begin
            if (cnt_r != CNT_ONE)  rd_data_next_s = mem_r[rd_ptr_r + PTR_ONE];
            else if (push_s)       rd_data_next_s = rx_data;
            else                   rd_data_next_s = rd_data_r;
        end else begin
            rd_data_next_s = rd_data_r;
        end
    end

    // FIFO storage, pointers, flags and head register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
            wr_ptr_r  <= '0;
            rd_ptr_r  <= '0;
            cnt_r     <= CNT_ZERO;
            empty_r   <= 1'b1;
            full_r    <= 1'b0;
            overrun_r <= 1'b0;
            rd_data_r <= 8'h00;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= rx_data;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            cnt_r     <= cnt_next_s;
            empty_r   <= (cnt_next_s == CNT_ZERO);
            full_r    <= (cnt_next_s == CNT_FULL);
            overrun_r <= overrun_next_s;
            rd_data_r <= rd_data_next_s;
        end
    end

    assign rec_en     = rec_en_r;
    assign rx_val_set = val_set_r;
    assign cfg_err    = cfg_err_r;
    assign comp       = comp_r;
    assign rd_data    = rd_data_r;
    assign fifo_empty = empty_r;
    assign fifo_full  = full_r;
    assign fifo_cnt   = cnt_r;
    assign overrun    = overrun_r;

endmodule

// File: tb/tb_nf_uart_rx_ctrl.sv
// Directed + randomized bench for nf_uart_rx_ctrl; a queue-based model predicts FIFO and flags.
module tb_nf_uart_rx_ctrl;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        cfg_en = 1'b0;
    logic        cfg_we = 1'b0;
    logic [15:0] cfg_comp = 16'd0;
    logic        cfg_err;
    logic        pop = 1'b0;
    logic [7:0]  rd_data;
    logic        fifo_empty;
    logic        fifo_full;
    logic [2:0]  fifo_cnt;
    logic        overrun;
    logic        ovr_clr = 1'b0;
    logic        rec_en;
    logic [15:0] comp;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_val_set;

    int total = 0;
    int bad = 0;
    int pulses = 0;

    logic [7:0] q[$];
    logic       ovr_m = 1'b0;
    logic [7:0] rd_m = 8'h00;

    nf_uart_rx_ctrl #(.FIFO_DEPTH(DEPTH), .DEFAULT_COMP(16'd434)) dut (
        .clk(clk), .resetn(resetn),
        .cfg_en(cfg_en), .cfg_we(cfg_we), .cfg_comp(cfg_comp), .cfg_err(cfg_err),
        .pop(pop), .rd_data(rd_data), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
        .fifo_cnt(fifo_cnt), .overrun(overrun), .ovr_clr(ovr_clr),
        .rec_en(rec_en), .comp(comp),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_val_set(rx_val_set)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        ovr_m = 1'b0;
        rd_m  = 8'h00;
    endtask

    task automatic upd_rd();
        if (q.size() > 0) rd_m = q[0];
    endtask

    task automatic check_fifo(input string tag);
        chk({tag, "_cnt"},   32'(fifo_cnt),   32'(q.size()));
        chk({tag, "_empty"}, 32'(fifo_empty), 32'(q.size() == 0));
        chk({tag, "_full"},  32'(fifo_full),  32'(q.size() == DEPTH));
        chk({tag, "_ovr"},   32'(overrun),    32'(ovr_m));
        chk({tag, "_rd"},    32'(rd_data),    32'(rd_m));
    endtask

    task automatic do_pop(input string tag);
        pop = 1'b1;
        tick();
        pop = 1'b0;
        if (q.size() > 0) void'(q.pop_front());
        upd_rd();
        check_fifo(tag);
    endtask

    // Acts as the receiver: raise rx_valid, wait for the ack, hold a while, then drop.
    task automatic send_byte(input logic [7:0] b, input bit pop_cap, input bit clr_cap, input int hold);
        bit seen = 1'b0;
        bit set_m;
        rx_data  = b;
        rx_valid = 1'b1;
        for (int i = 0; i < 8 && !seen; i++) begin
            tick();
            if (rx_val_set === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            chk("ack_timeout", 32'(seen), 32'(1));
            rx_valid = 1'b0;
            tick();
            return;
        end
        pulses++;
        chk("rec_en_capture", 32'(rec_en), 32'(1));
        pop     = pop_cap;
        ovr_clr = clr_cap;
        tick();
        pop     = 1'b0;
        ovr_clr = 1'b0;
        if (pop_cap && q.size() > 0) void'(q.pop_front());
        set_m = 1'b0;
        if (q.size() < DEPTH) q.push_back(b);
        else                  set_m = 1'b1;
        if (set_m)        ovr_m = 1'b1;
        else if (clr_cap) ovr_m = 1'b0;
        upd_rd();
        chk("ack_one_cycle", 32'(rx_val_set), 32'(0));
        chk("rec_en_wait", 32'(rec_en), 32'(1));
        check_fifo("capture");
        for (int h = 0; h < hold; h++) begin
            tick();
            chk("no_recapture", 32'(rx_val_set), 32'(0));
            chk("rec_en_hold", 32'(rec_en), 32'(1));
        end
        rx_valid = 1'b0;
        tick();
        chk("rec_en_after", 32'(rec_en), 32'(cfg_en));
    endtask

    initial begin
        string      msg;
        logic [7:0] b;
        int         p0;

        // reset state
        repeat (2) tick();
        chk("rst_rec_en", 32'(rec_en), 32'(0));
        chk("rst_comp", 32'(comp), 32'(434));
        chk("rst_val_set", 32'(rx_val_set), 32'(0));
        chk("rst_cfg_err", 32'(cfg_err), 32'(0));
        check_fifo("rst");
        resetn = 1'b1;
        tick();

        // enable and receive a message, popping after every byte
        cfg_en = 1'b1;
        tick();
        chk("enable_rec_en", 32'(rec_en), 32'(1));
        msg = "Hello World!";
        p0 = pulses;
        for (int i = 0; i < msg.len(); i++) begin
            send_byte(msg[i], 1'b0, 1'b0, int'($urandom_range(0, 2)));
            chk("hello_head", 32'(rd_data), 32'(msg[i]));
            do_pop("hello_pop");
        end
        chk("hello_pulses", 32'(pulses - p0), 32'(12));

        // overrun: five bytes into a four-entry FIFO
        for (int i = 0; i < 5; i++) begin
            send_byte(8'h11 + 8'(i), 1'b0, 1'b0, 0);
            if (i == 3) chk("ovr_full4", 32'(fifo_full), 32'(1));
        end
        chk("ovr_set", 32'(overrun), 32'(1));
        for (int i = 0; i < 4; i++) begin
            chk("ovr_pop_val", 32'(rd_data), 32'(8'h11 + 8'(i)));
            do_pop("ovr_pop");
        end
        chk("ovr_empty", 32'(fifo_empty), 32'(1));
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        ovr_m = 1'b0;
        check_fifo("ovr_clr");

        // config lockout outside IDLE, accepted in IDLE
        cfg_comp = 16'd217;
        cfg_we   = 1'b1;
        tick();
        cfg_we = 1'b0;
        chk("lock_err", 32'(cfg_err), 32'(1));
        chk("lock_comp", 32'(comp), 32'(434));
        tick();
        chk("lock_err_pulse", 32'(cfg_err), 32'(0));
        cfg_en = 1'b0;
        tick();
        chk("idle_rec_en", 32'(rec_en), 32'(0));
        cfg_we = 1'b1;
        tick();
        cfg_we = 1'b0;
        chk("idle_comp", 32'(comp), 32'(217));
        chk("idle_no_err", 32'(cfg_err), 32'(0));
        cfg_en = 1'b1;
        tick();
        b = 8'($urandom_range(0, 255));
        send_byte(b, 1'b0, 1'b0, int'($urandom_range(0, 2)));
        chk("fast_byte", 32'(rd_data), 32'(b));
        do_pop("fast_pop");

        // disable coinciding with the byte: it is still captured and acknowledged
        cfg_en = 1'b0;
        send_byte(8'hA5, 1'b0, 1'b0, 1);
        chk("dis_rec_en", 32'(rec_en), 32'(0));
        chk("dis_byte", 32'(rd_data), 32'(8'hA5));
        do_pop("dis_pop");

        // boundaries
        do_pop("pop_empty");
        cfg_en = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) send_byte(8'($urandom_range(0, 255)), 1'b0, 1'b0, 0);
        send_byte(8'h5A, 1'b1, 1'b0, 0);
        chk("full_pop_cnt", 32'(fifo_cnt), 32'(4));
        chk("full_pop_ovr", 32'(overrun), 32'(0));
        send_byte(8'h6B, 1'b0, 1'b1, 0);
        chk("set_wins", 32'(overrun), 32'(1));
        for (int i = 0; i < 4; i++) do_pop("drain");
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        ovr_m = 1'b0;
        check_fifo("drain_clr");

        // async reset mid-clock with three bytes buffered and the handshake in WAIT_CLR
        cfg_we = 1'b0;
        cfg_en = 1'b0;
        tick();
        cfg_we = 1'b1;
        cfg_comp = 16'd100;
        tick();
        cfg_we = 1'b0;
        cfg_en = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) send_byte(8'($urandom_range(0, 255)), 1'b0, 1'b0, 0);
        b = 8'hC3;
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        tick();
        chk("pre_rst_cnt", 32'(fifo_cnt), 32'(3));
        cfg_en = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_cnt", 32'(fifo_cnt), 32'(0));
        chk("arst_rec_en", 32'(rec_en), 32'(0));
        chk("arst_comp", 32'(comp), 32'(434));
        chk("arst_empty", 32'(fifo_empty), 32'(1));
        model_reset();
        tick();
        resetn = 1'b1;
        repeat (2) tick();
        chk("post_rst_idle", 32'(rec_en), 32'(0));
        chk("post_rst_no_ack", 32'(rx_val_set), 32'(0));
        cfg_en = 1'b1;
        send_byte(b, 1'b0, 1'b0, 0);
        chk("rehandled", 32'(rd_data), 32'(b));
        check_fifo("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nf_uart_rx_ctrl.md
Name: nf_uart_rx_ctrl

Overview:
Controller that sequences nf_uart_receiver.
- Owns the receiver's enable and baud-compare configuration.
- Acknowledges each received byte via the rx_valid / rx_val_set handshake.
- Buffers received bytes in a small first-word-fall-through (FWFT) FIFO with sticky overrun detection.
- Sits between the receiver and the bus-side UART register block, which pops bytes and reads status.

Parameters:
FIFO_DEPTH, 4, number of byte entries in the receive FIFO; power of two, >= 2.
DEFAULT_COMP, 434, baud-compare value loaded at reset (50 MHz / 115200).

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
cfg_en  in  1  enable request from the register block; level
cfg_we  in  1  comp write strobe
cfg_comp  in  16  new baud-compare value
cfg_err  out  1  one-cycle pulse: comp write rejected
pop  in  1  remove the head FIFO entry
rd_data  out  8  head FIFO entry (FWFT)
fifo_empty  out  1  FIFO holds 0 entries
fifo_full  out  1  FIFO holds FIFO_DEPTH entries
fifo_cnt  out  $clog2(FIFO_DEPTH)+1  current entry count
overrun  out  1  sticky flag: a byte was lost because the FIFO was full
ovr_clr  in  1  clears overrun
rec_en  out  1  receiver enable
comp  out  16  receiver baud-compare value
rx_data  in  8  receiver byte
rx_valid  in  1  receiver byte ready; held until acknowledged
rx_val_set  out  1  one-cycle acknowledge/clear to the receiver

Behaviour:
- Reset (asynchronous, resetn=0) forces:
  - state=IDLE, rec_en=0, comp=DEFAULT_COMP, rx_val_set=0, cfg_err=0.
  - FIFO pointers and fifo_cnt = 0; fifo_empty=1, fifo_full=0.
  - overrun=0, rd_data=0.
- All other logic updates on posedge clk.
- FSM states:
  - IDLE: rec_en=0. If cfg_en=1 -> RUN next cycle.
  - RUN: rec_en=1.
    - If rx_valid=1 -> CAPTURE (rx_valid takes priority over cfg_en).
    - Else if cfg_en=0 -> IDLE.
  - CAPTURE: rec_en=1, one cycle.
    - Writes rx_data into the FIFO if not full, else sets overrun=1 and discards the byte.
    - Drives rx_val_set=1 this cycle.
    - -> WAIT_CLR.
  - WAIT_CLR: rec_en=1, rx_val_set=0.
    - When rx_valid=0: -> RUN if cfg_en=1, else IDLE.
    - While rx_valid=1: stays, and does not re-capture.
- Latency: a byte is visible on rd_data with fifo_empty=0 in the cycle after CAPTURE, i.e. 2 clocks after rx_valid rises while in RUN.
- A disable during reception: rec_en stays 1 until the in-flight byte is captured and the handshake completes. No byte is dropped by disabling.
- comp writes:
  - cfg_we=1 in IDLE: comp<=cfg_comp next cycle.
  - cfg_we=1 in any other state: comp is unchanged and cfg_err pulses 1 for one cycle.
- FIFO:
  - FWFT: rd_data always equals the head entry. When empty, rd_data holds its last value.
  - pop when empty: ignored; no pointer or count change.
  - Simultaneous push (CAPTURE) and pop when full: both occur, fifo_cnt unchanged, no overrun.
  - Simultaneous push and pop when empty: push occurs, pop ignored, fifo_cnt=1.
  - Pointers are $clog2(FIFO_DEPTH) bits wide and wrap naturally modulo FIFO_DEPTH.
  - fifo_cnt saturation is impossible by construction.
- overrun:
  - Set when CAPTURE happens while fifo_full=1 and pop=0.
  - Cleared by ovr_clr=1.
  - If set and clear occur in the same cycle, set wins.
- Reset mid-operation (any state, any FIFO level) returns everything to the reset values immediately. The receiver's pending rx_valid is re-handled after reset only once cfg_en=1 again.

Test Plan:
- Enable and receive: reset, cfg_en=1, send "Hello World!" at comp=434.
  - Expect 12 rx_val_set pulses.
  - Popping after each byte returns 0x48, 0x65, 0x6C, ... 0x21 in order.
  - overrun=0 throughout.
- Overrun: FIFO_DEPTH=4, send 5 bytes 0x11..0x15 with no pops.
  - Expect fifo_full=1 after byte 4 and overrun=1 after byte 5.
  - Pops yield 0x11..0x14, then fifo_empty=1.
  - ovr_clr then gives overrun=0.
- Config lockout:
  - cfg_we with cfg_comp=217 while in RUN -> cfg_err pulses, comp stays 434.
  - Same write in IDLE -> comp=217 next cycle; a byte at 230400 baud is received correctly.
- Disable mid-byte: drop cfg_en during the start bit of 0xA5.
  - Expect rec_en to stay 1 until WAIT_CLR completes.
  - Byte 0xA5 is in the FIFO; then rec_en=0.
- Boundaries:
  - pop on empty -> fifo_cnt stays 0.
  - Capture coincident with pop at full -> fifo_cnt stays 4, overrun=0.
  - Set and ovr_clr in the same cycle -> overrun=1.
- Async reset: assert resetn=0 mid-clock while 3 bytes are buffered and in WAIT_CLR.
  - Outputs reach reset values without waiting for a clock edge: fifo_cnt=0, rec_en=0, comp=434.
